// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the paged tracklet memory and its write-side sequencer.
package mem_ctrl_pkg;

    localparam int NENT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } state_t;

    // Ceiling log2. Also used by the memory so both sides agree on address widths.
    function automatic int clogb2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_nent_strobe.sv
// Builds the registered per-page nent_i / nent_we buses from close, open and
// live-count events. Each byte of nent_i holds the last value strobed into it.
module mem_nent_strobe
    import mem_ctrl_pkg::*;
#(
    parameter int NPAGE = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      close_en,
    input  logic [clogb2(NPAGE)-1:0]  close_page,
    input  logic [NENT_W-1:0]         close_cnt,
    input  logic                      open_en,
    input  logic [clogb2(NPAGE)-1:0]  open_page,
    input  logic [NENT_W-1:0]         open_cnt,
    input  logic                      live_en,
    input  logic [clogb2(NPAGE)-1:0]  live_page,
    input  logic [NENT_W-1:0]         live_cnt,
    output logic [NENT_W*NPAGE-1:0]   nent_i,
    output logic [NPAGE-1:0]          nent_we
);

    logic [NENT_W*NPAGE-1:0] nent_nxt;
    logic [NPAGE-1:0]        we_nxt;

    // Merge events; open is applied after close so a reopened page reports its fresh count.
    always_comb begin
        nent_nxt = nent_i;
        we_nxt   = '0;
        if (close_en) begin
            we_nxt[close_page] = 1'b1;
            nent_nxt[int'(close_page)*NENT_W +: NENT_W] = close_cnt;
        end
        if (open_en) begin
            we_nxt[open_page] = 1'b1;
            nent_nxt[int'(open_page)*NENT_W +: NENT_W] = open_cnt;
        end
        if (live_en) begin
            we_nxt[live_page] = 1'b1;
            nent_nxt[int'(live_page)*NENT_W +: NENT_W] = live_cnt;
        end
    end

    // Register the strobes and values together so they reach the memory in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nent_i  <= '0;
            nent_we <= '0;
        end else begin
            nent_i  <= nent_nxt;
            nent_we <= we_nxt;
        end
    end

endmodule

// File: rtl/mem_page_write_ctrl.sv
// Write-side sequencer for the paged tracklet memory: maps each event (BX)
// to page bx mod NPAGE, writes its words to {page, entry}, counts entries
// per page and drives the per-page nent registers.
//
// state  | meaning
// IDLE   | no page open; incoming words are ignored
// ACTIVE | page open, words written at {page, cnt}
// FULL   | page holds PAGE_DEPTH entries; words are dropped and counted
module mem_page_write_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int RAM_WIDTH  = 18,
    parameter int RAM_DEPTH  = 1024,
    parameter int NPAGE      = 8,
    parameter int PAGE_DEPTH = RAM_DEPTH / NPAGE,
    parameter int LIVE_NENT  = 0,
    parameter int DROP_W     = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           bx_start,
    input  logic [clogb2(NPAGE)-1:0]       bx,
    input  logic [RAM_WIDTH-1:0]           din,
    input  logic                           din_valid,
    output logic [clogb2(RAM_DEPTH)-1:0]   addra,
    output logic [RAM_WIDTH-1:0]           dina,
    output logic                           wea,
    output logic [NENT_W*NPAGE-1:0]        nent_i,
    output logic [NPAGE-1:0]               nent_we,
    output logic                           page_full,
    output logic [NPAGE-1:0]               overflow,
    output logic [DROP_W-1:0]              drop_cnt
);

    localparam int PW = clogb2(NPAGE);
    localparam int EW = clogb2(PAGE_DEPTH);

    state_t            state;
    state_t            state_nxt;
    logic [PW-1:0]     page;
    logic [NENT_W-1:0] cnt;
    logic [NENT_W-1:0] cnt_nxt;
    logic [NENT_W-1:0] cnt_inc;
    logic              accept;
    logic              drop;
    logic              close_en;
    logic              live_en;
    logic [PW-1:0]     wr_page;
    logic [EW-1:0]     wr_entry;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a new event always opens a page; a page fills when cnt reaches PAGE_DEPTH.
    always_comb begin
        state_nxt = state;
        if (bx_start) begin
            state_nxt = (cnt_nxt == NENT_W'(PAGE_DEPTH)) ? FULL : ACTIVE;
        end else if (state == ACTIVE && cnt_nxt == NENT_W'(PAGE_DEPTH)) begin
            state_nxt = FULL;
        end
    end

    // Per-cycle decode; a word arriving with bx_start belongs to the new page at entry 0.
    always_comb begin
        accept   = din_valid && (bx_start || state == ACTIVE);
        drop     = din_valid && !bx_start && state == FULL;
        close_en = bx_start && state != IDLE;
        live_en  = (LIVE_NENT != 0) && accept && !bx_start;
        wr_page  = bx_start ? bx : page;
        wr_entry = bx_start ? '0 : cnt[EW-1:0];
        cnt_inc  = cnt + NENT_W'(1);
        if (bx_start) begin
            cnt_nxt = NENT_W'(din_valid);
        end else if (accept) begin
            cnt_nxt = cnt_inc;
        end else begin
            cnt_nxt = cnt;
        end
    end

    // Page/entry tracking, memory write port and drop bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            page     <= '0;
            cnt      <= '0;
            wea      <= 1'b0;
            addra    <= '0;
            dina     <= '0;
            overflow <= '0;
            drop_cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
            wea <= accept;
            if (bx_start) begin
                page         <= bx;
                overflow[bx] <= 1'b0;
            end else if (drop) begin
                overflow[page] <= 1'b1;
            end
            if (accept) begin
                addra <= {wr_page, wr_entry};
                dina  <= din;
            end
            if (drop && drop_cnt != {DROP_W{1'b1}}) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end

    assign page_full = (state == FULL);

    mem_nent_strobe #(
        .NPAGE (NPAGE)
    ) u_nent_strobe (
        .clk        (clk),
        .rst_n      (rst_n),
        .close_en   (close_en),
        .close_page (page),
        .close_cnt  (cnt),
        .open_en    (bx_start),
        .open_page  (bx),
        .open_cnt   (NENT_W'(din_valid)),
        .live_en    (live_en),
        .live_page  (page),
        .live_cnt   (cnt_inc),
        .nent_i     (nent_i),
        .nent_we    (nent_we)
    );

endmodule

// File: tb/tb_mem_page_write_ctrl.sv
// Bench for mem_page_write_ctrl: two instances (LIVE_NENT=0 and 1) share the
// same stimulus and are compared against an event-level reference model.
module tb_mem_page_write_ctrl;

    localparam int PD = 128;
    localparam int NP = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bx_start = 1'b0;
    logic [2:0]  bx = '0;
    logic [17:0] din = '0;
    logic        din_valid = 1'b0;

    logic [9:0]  a_addra, b_addra;
    logic [17:0] a_dina, b_dina;
    logic        a_wea, b_wea;
    logic [63:0] a_nent_i, b_nent_i;
    logic [7:0]  a_nent_we, b_nent_we;
    logic        a_page_full, b_page_full;
    logic [7:0]  a_overflow, b_overflow;
    logic [15:0] a_drop_cnt, b_drop_cnt;

    mem_page_write_ctrl #(.LIVE_NENT(0)) dut (
        .clk(clk), .rst_n(rst_n), .bx_start(bx_start), .bx(bx), .din(din),
        .din_valid(din_valid), .addra(a_addra), .dina(a_dina), .wea(a_wea),
        .nent_i(a_nent_i), .nent_we(a_nent_we), .page_full(a_page_full),
        .overflow(a_overflow), .drop_cnt(a_drop_cnt)
    );

    mem_page_write_ctrl #(.LIVE_NENT(1)) dut_live (
        .clk(clk), .rst_n(rst_n), .bx_start(bx_start), .bx(bx), .din(din),
        .din_valid(din_valid), .addra(b_addra), .dina(b_dina), .wea(b_wea),
        .nent_i(b_nent_i), .nent_we(b_nent_we), .page_full(b_page_full),
        .overflow(b_overflow), .drop_cnt(b_drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: one open page with an integer fill level.
    bit          m_open;
    int          m_page;
    int          m_cnt;
    bit [7:0]    m_ovf;
    int          m_drop;
    bit          e_wea;
    int          e_addr;
    logic [17:0] e_dina;
    bit [7:0]    e_we [2];
    int          e_val [2][NP];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_open = 0; m_page = 0; m_cnt = 0; m_ovf = '0; m_drop = 0;
        e_wea = 0; e_we[0] = '0; e_we[1] = '0;
    endtask

    task automatic model_step(input bit bs, input int b, input bit dv, input logic [17:0] d);
        e_wea = 0; e_we[0] = '0; e_we[1] = '0;
        if (bs) begin
            if (m_open) begin
                for (int c = 0; c < 2; c++) begin
                    e_we[c][m_page] = 1'b1;
                    e_val[c][m_page] = m_cnt;
                end
            end
            m_page = b; m_cnt = dv ? 1 : 0; m_open = 1; m_ovf[b] = 1'b0;
            for (int c = 0; c < 2; c++) begin
                e_we[c][b] = 1'b1;
                e_val[c][b] = m_cnt;
            end
            if (dv) begin
                e_wea = 1; e_addr = b * PD; e_dina = d;
            end
        end else if (m_open && dv) begin
            if (m_cnt < PD) begin
                e_wea = 1; e_addr = m_page * PD + m_cnt; e_dina = d;
                m_cnt++;
                e_we[1][m_page] = 1'b1;
                e_val[1][m_page] = m_cnt;
            end else begin
                if (m_drop < 65535) m_drop++;
                m_ovf[m_page] = 1'b1;
            end
        end
    endtask

    task automatic check_outputs(input string ph);
        check({ph, ".wea"}, a_wea, e_wea);
        check({ph, ".wea_live"}, b_wea, e_wea);
        if (e_wea) begin
            check({ph, ".addra"}, a_addra, e_addr);
            check({ph, ".dina"}, a_dina, e_dina);
            check({ph, ".addra_live"}, b_addra, e_addr);
        end
        check({ph, ".nent_we"}, a_nent_we, e_we[0]);
        check({ph, ".nent_we_live"}, b_nent_we, e_we[1]);
        for (int k = 0; k < NP; k++) begin
            if (e_we[0][k]) check({ph, ".nent_i"}, a_nent_i[k*8 +: 8], e_val[0][k]);
            if (e_we[1][k]) check({ph, ".nent_i_live"}, b_nent_i[k*8 +: 8], e_val[1][k]);
        end
        check({ph, ".page_full"}, a_page_full, m_open && m_cnt == PD);
        check({ph, ".page_full_live"}, b_page_full, m_open && m_cnt == PD);
        check({ph, ".overflow"}, a_overflow, m_ovf);
        check({ph, ".drop_cnt"}, a_drop_cnt, m_drop);
        check({ph, ".drop_cnt_live"}, b_drop_cnt, m_drop);
    endtask

    task automatic step(input string ph, input bit bs, input int b, input bit dv, input logic [17:0] d);
        bx_start = bs; bx = b[2:0]; din_valid = dv; din = d;
        model_step(bs, b, dv, d);
        @(posedge clk);
        #1;
        bx_start = 1'b0; din_valid = 1'b0;
        check_outputs(ph);
    endtask

    task automatic check_all_zero(input string ph);
        check({ph, ".wea"}, a_wea, 0);
        check({ph, ".addra"}, a_addra, 0);
        check({ph, ".dina"}, a_dina, 0);
        check({ph, ".nent_i"}, a_nent_i, 0);
        check({ph, ".nent_we"}, a_nent_we, 0);
        check({ph, ".page_full"}, a_page_full, 0);
        check({ph, ".overflow"}, a_overflow, 0);
        check({ph, ".drop_cnt"}, a_drop_cnt, 0);
        check({ph, ".nent_i_live"}, b_nent_i, 0);
        check({ph, ".drop_cnt_live"}, b_drop_cnt, 0);
    endtask

    initial begin
        // Power-on reset.
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Words in IDLE are ignored and not counted.
        for (int i = 0; i < 3; i++) step("idle", 0, 0, 1, 18'($urandom));

        // Page 3, five words, then page 4 closes it.
        step("t1.open", 1, 3, 0, 0);
        for (int i = 1; i <= 5; i++) step("t1.word", 0, 0, 1, 18'(i));
        step("t1.close", 1, 4, 0, 0);
        check("t1.nent_we_lit", a_nent_we, 8'h18);
        check("t1.nent_i3_lit", a_nent_i[31:24], 8'd5);

        // Page 0 overfilled by two words.
        step("t2.open", 1, 0, 0, 0);
        for (int i = 0; i < 130; i++) step("t2.word", 0, 0, 1, 18'($urandom));
        check("t2.drop_lit", a_drop_cnt, 16'd2);
        check("t2.ovf_lit", a_overflow, 8'h01);
        check("t2.full_lit", a_page_full, 1'b1);

        // bx_start together with a word: word lands at entry 0 of page 1.
        step("t3.open_word", 1, 1, 1, 18'h0ABC);
        check("t3.addra_lit", a_addra, 10'd128);
        check("t3.nent_i0_lit", a_nent_i[7:0], 8'd128);
        check("t3.full_lit", a_page_full, 1'b0);

        // Live nent on page 2.
        step("t5.open", 1, 2, 0, 0);
        for (int i = 0; i < 3; i++) step("t5.word", 0, 0, 1, 18'($urandom));

        // Reopen the same page.
        step("reopen", 1, 2, 1, 18'h1234);

        // Reset in the middle of page 6.
        step("t6.open", 1, 6, 0, 0);
        for (int i = 0; i < 4; i++) step("t6.word", 0, 0, 1, 18'($urandom));
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all_zero("t6.reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step("t6.after", 0, 0, 1, 18'($urandom));
        step("t6.reopen", 1, 6, 1, 18'h00055);

        // Random traffic with frequent events.
        for (int i = 0; i < 400; i++) begin
            step("rand", $urandom_range(0, 15) == 0, $urandom_range(0, NP - 1),
                 $urandom_range(0, 3) != 0, 18'($urandom));
        end

        // Random traffic long enough to fill pages.
        for (int r = 0; r < 3; r++) begin
            step("fill.open", 1, $urandom_range(0, NP - 1), $urandom_range(0, 1) != 0, 18'($urandom));
            for (int i = 0; i < 150; i++) begin
                step("fill", 0, 0, $urandom_range(0, 7) != 0, 18'($urandom));
            end
        end
        step("fill.close", 1, $urandom_range(0, NP - 1), 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
